// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BHT/JAL next-PC prediction, and the IF/ID register for decode.
// Define FETCH_BHT_EN to build the 2-bit counter BHT; otherwise branches are statically not-taken.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter int          BHT_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_ID_en,
  input  logic        mispredict,
  input  logic [31:0] redirect_pc,
  input  logic        syscall_halt,
  input  logic        bht_upd_en,
  input  logic [31:0] bht_upd_pc,
  input  logic        bht_upd_taken,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_D,
  output logic [31:0] instr_D,
  output logic [1:0]  br_hist_D,
  output logic        predict_D
);

  localparam int          IDX_W     = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t             state, state_next;
  logic [31:0]        pc_F, pc_next;
  logic [1:0]         ctr;
  logic               taken;
  logic               halt;
  logic signed [31:0] imm_b, imm_j;

  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

`ifdef FETCH_BHT_EN
  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             unused_upd_bits;

  assign rd_idx          = pc_F[IDX_W+1:2];
  assign wr_idx          = bht_upd_pc[IDX_W+1:2];
  assign ctr             = bht[rd_idx];
  assign unused_upd_bits = ^{bht_upd_pc[31:IDX_W+2], bht_upd_pc[1:0]};

  // BHT write port: the lookup above always sees the value before this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (bht_upd_en) begin
      bht[wr_idx] <= sat_update(bht[wr_idx], bht_upd_taken);
    end
  end
`else
  logic unused_upd;

  // weakly-not-taken constant makes every branch fall through
  assign ctr        = 2'b01;
  assign unused_upd = ^{bht_upd_en, bht_upd_pc, bht_upd_taken, sat_update(2'b00, 1'b0)};
`endif

  assign imem_addr = pc_F;
  assign halt      = syscall_halt || (state == S_HALT);

  always_comb begin
    imm_b   = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25], imem_rdata[11:8], 1'b0};
    imm_j   = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20], imem_rdata[30:21], 1'b0};
    taken   = 1'b0;
    pc_next = pc_F + 32'd4;
    case (imem_rdata[6:0])
      OP_BRANCH: begin
        if (ctr[1]) begin
          taken   = 1'b1;
          pc_next = pc_F + $unsigned(imm_b);
        end
      end
      OP_JAL: begin
        taken   = 1'b1;
        pc_next = pc_F + $unsigned(imm_j);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    if (state == S_RUN && syscall_halt && !mispredict) state_next = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_next;
  end

  // IF -> ID boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_F      <= RESET_PC;
      pc_D      <= 32'd0;
      instr_D   <= NOP;
      br_hist_D <= 2'b00;
      predict_D <= 1'b0;
    end else if (mispredict) begin
      pc_F      <= redirect_pc;
      pc_D      <= 32'd0;
      instr_D   <= NOP;
      br_hist_D <= 2'b00;
      predict_D <= 1'b0;
    end else if (halt) begin
      pc_D      <= 32'd0;
      instr_D   <= NOP;
      br_hist_D <= 2'b00;
      predict_D <= 1'b0;
    end else if (IF_ID_en) begin
      pc_F      <= pc_next;
      pc_D      <= pc_F;
      instr_D   <= imem_rdata;
      br_hist_D <= ctr;
      predict_D <= taken;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; expectations adapt to whether FETCH_BHT_EN is defined.
module tb_fetch_stage;

`ifdef FETCH_BHT_EN
  localparam bit HAS_BHT = 1'b1;
`else
  localparam bit HAS_BHT = 1'b0;
`endif

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] BEQ16  = 32'h0000_0863;  // beq x0,x0,+16
  localparam logic [31:0] JALM8  = 32'hFF9F_F06F;  // jal x0,-8
  localparam logic [31:0] ADDI   = 32'h0010_0093;  // addi x1,x0,1

  logic        clk = 1'b0;
  logic        rst, IF_ID_en, mispredict, syscall_halt;
  logic        bht_upd_en, bht_upd_taken;
  logic [31:0] redirect_pc, bht_upd_pc, imem_rdata;
  logic [31:0] imem_addr, pc_D, instr_D;
  logic [1:0]  br_hist_D;
  logic        predict_D;

  int errors = 0;
  int checks = 0;

  fetch_stage #(.RESET_PC(RST_PC), .BHT_ENTRIES(64)) dut (
    .clk(clk), .rst(rst), .IF_ID_en(IF_ID_en), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .syscall_halt(syscall_halt), .bht_upd_en(bht_upd_en),
    .bht_upd_pc(bht_upd_pc), .bht_upd_taken(bht_upd_taken), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .pc_D(pc_D), .instr_D(instr_D), .br_hist_D(br_hist_D),
    .predict_D(predict_D)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    mispredict  = 1'b1;
    redirect_pc = target;
    imem_rdata  = NOP;
    step();
    mispredict  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; IF_ID_en = 1'b1; mispredict = 1'b0; syscall_halt = 1'b0;
    bht_upd_en = 1'b0; bht_upd_taken = 1'b0; bht_upd_pc = 32'd0; redirect_pc = 32'd0;
    imem_rdata = NOP;
    step(); step();
    rst = 1'b0;
    checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, RST_PC); end
    checks++; if (pc_D !== 32'd0) begin errors++; $display("FAIL reset_pc_D: got %h want 0", pc_D); end
    checks++; if (instr_D !== NOP) begin errors++; $display("FAIL reset_instr_D: got %h want %h", instr_D, NOP); end
    checks++; if (br_hist_D !== 2'b00) begin errors++; $display("FAIL reset_br_hist: got %b want 00", br_hist_D); end
    checks++; if (predict_D !== 1'b0) begin errors++; $display("FAIL reset_predict: got %b want 0", predict_D); end
    for (int i = 1; i <= 2; i++) begin
      step();
      checks++; if (imem_addr !== RST_PC + 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, imem_addr, RST_PC + 32'(4 * i)); end
      checks++; if (pc_D !== RST_PC + 32'(4 * (i - 1))) begin errors++; $display("FAIL seq_pc_D%0d: got %h want %h", i, pc_D, RST_PC + 32'(4 * (i - 1))); end
      checks++; if (instr_D !== NOP) begin errors++; $display("FAIL seq_instr%0d: got %h want %h", i, instr_D, NOP); end
    end
    checks++; if (br_hist_D !== 2'b01) begin errors++; $display("FAIL seq_br_hist: got %b want 01", br_hist_D); end
  endtask

  task automatic test_branch();
    step(); step();
    checks++; if (imem_addr !== 32'h0040_0010) begin errors++; $display("FAIL br_setup_addr: got %h want 00400010", imem_addr); end
    imem_rdata = BEQ16;
    step();
    checks++; if (imem_addr !== 32'h0040_0014) begin errors++; $display("FAIL br_fresh_addr: got %h want 00400014", imem_addr); end
    checks++; if (pc_D !== 32'h0040_0010) begin errors++; $display("FAIL br_fresh_pc_D: got %h want 00400010", pc_D); end
    checks++; if (instr_D !== BEQ16) begin errors++; $display("FAIL br_fresh_instr: got %h want %h", instr_D, BEQ16); end
    checks++; if (predict_D !== 1'b0) begin errors++; $display("FAIL br_fresh_predict: got %b want 0", predict_D); end
    checks++; if (br_hist_D !== 2'b01) begin errors++; $display("FAIL br_fresh_hist: got %b want 01", br_hist_D); end
    bht_upd_en = 1'b1; bht_upd_pc = 32'h0040_0010; bht_upd_taken = 1'b1;
    redirect(32'h0040_0010);
    checks++; if (imem_addr !== 32'h0040_0010) begin errors++; $display("FAIL br_redir_addr: got %h want 00400010", imem_addr); end
    checks++; if (instr_D !== NOP) begin errors++; $display("FAIL br_bubble_instr: got %h want %h", instr_D, NOP); end
    checks++; if (pc_D !== 32'd0) begin errors++; $display("FAIL br_bubble_pc_D: got %h want 0", pc_D); end
    checks++; if (br_hist_D !== 2'b00) begin errors++; $display("FAIL br_bubble_hist: got %b want 00", br_hist_D); end
    IF_ID_en = 1'b0;
    step();
    checks++; if (imem_addr !== 32'h0040_0010) begin errors++; $display("FAIL br_stall_addr: got %h want 00400010", imem_addr); end
    bht_upd_en = 1'b0; IF_ID_en = 1'b1; imem_rdata = BEQ16;
    step();
    checks++; if (imem_addr !== (HAS_BHT ? 32'h0040_0020 : 32'h0040_0014)) begin errors++; $display("FAIL br_trained_addr: got %h want %h", imem_addr, HAS_BHT ? 32'h0040_0020 : 32'h0040_0014); end
    checks++; if (predict_D !== HAS_BHT) begin errors++; $display("FAIL br_trained_predict: got %b want %b", predict_D, HAS_BHT); end
    checks++; if (br_hist_D !== (HAS_BHT ? 2'b11 : 2'b01)) begin errors++; $display("FAIL br_trained_hist: got %b want %b", br_hist_D, HAS_BHT ? 2'b11 : 2'b01); end
  endtask

  task automatic test_jal();
    redirect(32'h0040_0000);
    imem_rdata = JALM8;
    step();
    checks++; if (imem_addr !== 32'h003F_FFF8) begin errors++; $display("FAIL jal_addr: got %h want 003ffff8", imem_addr); end
    checks++; if (predict_D !== 1'b1) begin errors++; $display("FAIL jal_predict: got %b want 1", predict_D); end
    checks++; if (pc_D !== 32'h0040_0000) begin errors++; $display("FAIL jal_pc_D: got %h want 00400000", pc_D); end
    checks++; if (instr_D !== JALM8) begin errors++; $display("FAIL jal_instr: got %h want %h", instr_D, JALM8); end
    checks++; if (br_hist_D !== 2'b01) begin errors++; $display("FAIL jal_hist: got %b want 01", br_hist_D); end
  endtask

  task automatic test_stall();
    imem_rdata = ADDI;
    step();
    checks++; if (imem_addr !== 32'h003F_FFFC) begin errors++; $display("FAIL stall_pre_addr: got %h want 003ffffc", imem_addr); end
    checks++; if (instr_D !== ADDI) begin errors++; $display("FAIL stall_pre_instr: got %h want %h", instr_D, ADDI); end
    IF_ID_en = 1'b0; imem_rdata = JALM8;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (imem_addr !== 32'h003F_FFFC) begin errors++; $display("FAIL stall_addr%0d: got %h want 003ffffc", i, imem_addr); end
      checks++; if (pc_D !== 32'h003F_FFF8) begin errors++; $display("FAIL stall_pc_D%0d: got %h want 003ffff8", i, pc_D); end
      checks++; if (instr_D !== ADDI) begin errors++; $display("FAIL stall_instr%0d: got %h want %h", i, instr_D, ADDI); end
      checks++; if (predict_D !== 1'b0) begin errors++; $display("FAIL stall_predict%0d: got %b want 0", i, predict_D); end
    end
    redirect(32'h0040_0100);
    checks++; if (imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL stall_redir_addr: got %h want 00400100", imem_addr); end
    checks++; if (instr_D !== NOP) begin errors++; $display("FAIL stall_redir_instr: got %h want %h", instr_D, NOP); end
    checks++; if (pc_D !== 32'd0) begin errors++; $display("FAIL stall_redir_pc_D: got %h want 0", pc_D); end
  endtask

  task automatic test_saturation();
    imem_rdata = NOP;
    bht_upd_en = 1'b1; bht_upd_pc = 32'h0040_0010; bht_upd_taken = 1'b0;
    for (int i = 0; i < 4; i++) step();
    bht_upd_en = 1'b0;
    checks++; if (imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL sat_hold_addr: got %h want 00400100", imem_addr); end
    IF_ID_en = 1'b1;
    redirect(32'h0040_0010);
    imem_rdata = BEQ16;
    step();
    checks++; if (br_hist_D !== (HAS_BHT ? 2'b00 : 2'b01)) begin errors++; $display("FAIL sat_hist: got %b want %b", br_hist_D, HAS_BHT ? 2'b00 : 2'b01); end
    checks++; if (predict_D !== 1'b0) begin errors++; $display("FAIL sat_predict: got %b want 0", predict_D); end
    checks++; if (imem_addr !== 32'h0040_0014) begin errors++; $display("FAIL sat_addr: got %h want 00400014", imem_addr); end
    redirect(32'h0040_0010);
    imem_rdata = BEQ16; bht_upd_en = 1'b1; bht_upd_taken = 1'b1;
    step();
    bht_upd_en = 1'b0;
    checks++; if (br_hist_D !== (HAS_BHT ? 2'b00 : 2'b01)) begin errors++; $display("FAIL same_cycle_hist: got %b want %b", br_hist_D, HAS_BHT ? 2'b00 : 2'b01); end
    checks++; if (imem_addr !== 32'h0040_0014) begin errors++; $display("FAIL same_cycle_addr: got %h want 00400014", imem_addr); end
    redirect(32'h0040_0010);
    imem_rdata = BEQ16;
    step();
    checks++; if (br_hist_D !== 2'b01) begin errors++; $display("FAIL post_update_hist: got %b want 01", br_hist_D); end
  endtask

  task automatic test_halt();
    imem_rdata = ADDI; syscall_halt = 1'b1;
    bht_upd_en = 1'b1; bht_upd_pc = 32'h0040_0010; bht_upd_taken = 1'b1;
    step();
    syscall_halt = 1'b0; bht_upd_en = 1'b0;
    checks++; if (imem_addr !== 32'h0040_0014) begin errors++; $display("FAIL halt_addr: got %h want 00400014", imem_addr); end
    checks++; if (instr_D !== NOP) begin errors++; $display("FAIL halt_instr: got %h want %h", instr_D, NOP); end
    checks++; if (pc_D !== 32'd0) begin errors++; $display("FAIL halt_pc_D: got %h want 0", pc_D); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_addr !== 32'h0040_0014) begin errors++; $display("FAIL halt_hold_addr%0d: got %h want 00400014", i, imem_addr); end
      checks++; if (instr_D !== NOP) begin errors++; $display("FAIL halt_hold_instr%0d: got %h want %h", i, instr_D, NOP); end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL halt_rst_addr: got %h want %h", imem_addr, RST_PC); end
    checks++; if (instr_D !== NOP) begin errors++; $display("FAIL halt_rst_instr: got %h want %h", instr_D, NOP); end
    imem_rdata = ADDI;
    step();
    checks++; if (imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL unhalt_addr: got %h want 00400004", imem_addr); end
    checks++; if (instr_D !== ADDI) begin errors++; $display("FAIL unhalt_instr: got %h want %h", instr_D, ADDI); end
    redirect(32'h0040_0010);
    imem_rdata = BEQ16;
    step();
    checks++; if (br_hist_D !== 2'b01) begin errors++; $display("FAIL rst_bht_hist: got %b want 01", br_hist_D); end
    checks++; if (predict_D !== 1'b0) begin errors++; $display("FAIL rst_bht_predict: got %b want 0", predict_D); end
    checks++; if (imem_addr !== 32'h0040_0014) begin errors++; $display("FAIL rst_bht_addr: got %h want 00400014", imem_addr); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jal();
    test_stall();
    test_saturation();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of decode.
- Holds the architectural fetch PC and drives the instruction-memory address.
- Predicts conditional branches with a table of 2-bit saturating counters (BHT) and JAL as always taken.
- Registers pc_D, instr_D, br_hist_D and predict_D into the IF/ID pipeline register consumed by decode.

Parameters:
- RESET_PC, 32'h0040_0000, first fetch address after reset.
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, at least 2.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- IF_ID_en  input  1  1 = IF/ID register and PC advance; 0 = stall (hold both).
- mispredict  input  1  branch/jump resolved wrong downstream; redirect fetch.
- redirect_pc  input  32  correct target, valid when mispredict = 1.
- syscall_halt  input  1  halt seen; freeze PC and feed NOPs.
- bht_upd_en  input  1  write one BHT counter this cycle.
- bht_upd_pc  input  32  PC of the resolved branch.
- bht_upd_taken  input  1  actual branch outcome.
- imem_rdata  input  32  instruction at imem_addr, combinational read.
- imem_addr  output  32  equals pc_F.
- pc_D  output  32  PC of the instruction in IF/ID.
- instr_D  output  32  instruction in IF/ID.
- br_hist_D  output  2  BHT counter value used for that instruction's prediction.
- predict_D  output  1  1 = fetch followed the predicted-taken path.

Behaviour:
- Clocking: clk only. Reset is synchronous, active-high, sampled on the rising edge.
- Reset values:
  - pc_F = RESET_PC
  - instr_D = 32'h0000_0013 (NOP)
  - pc_D = 0, br_hist_D = 0, predict_D = 0
  - all BHT counters = 2'b01 (weakly not-taken)
- BHT index: pc[$clog2(BHT_ENTRIES)+1:2]. The same index function applies to bht_upd_pc.
- Prediction, combinational on imem_rdata:
  - opcode 7'b1100011 (branch): taken iff counter[1] = 1; target = pc_F + B-immediate (sign-extended, bit 0 = 0).
  - opcode 7'b1101111 (JAL): always taken; target = pc_F + J-immediate.
  - all other opcodes: next = pc_F + 4, predict = 0.
  - All adds are 32-bit modulo; wrap at 2^32 is not flagged.
- Priority per edge: rst > mispredict > syscall_halt > !IF_ID_en > normal.
  - mispredict: pc_F <= redirect_pc; IF/ID loads a NOP bubble (instr_D = NOP, pc_D = 0, predict_D = 0, br_hist_D = 0). This applies even when IF_ID_en = 0.
  - syscall_halt: pc_F holds; IF/ID loads a NOP bubble; remains in this state until reset.
  - stall: pc_F and all IF/ID outputs hold.
  - normal: pc_F <= predicted next; IF/ID <= {pc_F, imem_rdata, counter, predict}.
- Fetch latency: an instruction at pc_F appears on instr_D one cycle later.
- BHT update:
  - On the edge with bht_upd_en = 1: taken increments the counter, saturating at 3; not-taken decrements, saturating at 0.
  - Updates happen regardless of stall, halt or mispredict, but not during rst.
  - A lookup and an update to the same index in the same cycle: the lookup sees the pre-update value.
- Misalignment: imem_addr always carries bits [1:0] of pc_F unmodified. redirect_pc is assumed 4-byte aligned by the producer; the stage does no checking.

Optional Feature:
- Macro: FETCH_BHT_EN.
- Defined: BHT present as described above.
- Undefined:
  - No BHT storage.
  - Branches statically predicted not-taken.
  - br_hist_D reports 2'b01 for every fetched instruction.
  - JAL is still predicted taken.
  - bht_upd_* inputs are ignored.

Test Plan:
1. Reset with RESET_PC = 32'h0040_0000, then 3 cycles of NOP memory -> imem_addr 0x400000, 0x400004, 0x400008; instr_D = NOP throughout; pc_D lags imem_addr by one cycle.
2. Branch at 0x400010 with offset +16 and a fresh counter (01) -> next imem_addr = 0x400014, predict_D = 0, br_hist_D = 01. Then apply two bht_upd_taken = 1 updates and refetch -> next imem_addr = 0x400020, predict_D = 1, br_hist_D = 11.
3. JAL at 0x400000 with offset -8 -> imem_addr = 0x3FFFF8, predict_D = 1.
4. IF_ID_en = 0 for 2 cycles mid-stream -> pc_F and pc_D/instr_D hold. Raise mispredict with redirect_pc = 0x400100 while IF_ID_en = 0 -> imem_addr = 0x400100 next cycle, instr_D = NOP.
5. Saturation: four not-taken updates on one index, then fetch that branch -> br_hist_D = 00. A same-cycle update and lookup on that index returns the old value.
6. syscall_halt = 1 -> PC frozen, instr_D = NOP indefinitely. Assert rst mid-halt -> imem_addr = RESET_PC and all BHT counters read 01.
